// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Data memory and self-check responder for the M stage of the pipelined
// RISC-V core. Performs byte, halfword and word stores and loads with a
// one-cycle registered read latency. It also runs a small RUN/PASS/FAIL
// state machine that reports the end of a directed test program.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset (clears memory and state)
//   mem_write_m    store request this cycle
//   mem_read_m     load request this cycle
//   funct3_m       access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   data_address_m byte address
//   store_data_m   right-aligned store data
//   read_data_w    load result, valid the cycle after the request
//   access_err     sticky flag: misaligned, out-of-range or bad funct3 seen
//   store_count    number of performed stores, saturating at 16'hFFFF
//   done           run finished (PASS or FAIL)
//   pass           run finished successfully
//
// Request semantics: there is no back-pressure. A request is taken on the
// rising edge on which mem_write_m / mem_read_m is high and reset is low;
// a load answers on read_data_w right after that edge and the value is held
// until the next load.
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int          DEPTH_WORDS  = 64,
    parameter logic [31:0] PASS_ADDR    = 32'd100,
    parameter logic [31:0] PASS_DATA    = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR = 32'd96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_m,
    input  logic        mem_read_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] data_address_m,
    input  logic [31:0] store_data_m,
    output logic [31:0] read_data_w,
    output logic        access_err,
    output logic [15:0] store_count,
    output logic        done,
    output logic        pass
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

    // Stores are classified by the word they touch, so sub-word stores into
    // the scratch word (e.g. sb to 97) are tolerated, while any sb/sh into
    // the pass word counts as a failing pass attempt.
    localparam logic [29:0] PASS_WORD    = PASS_ADDR[31:2];
    localparam logic [29:0] SCRATCH_WORD = SCRATCH_ADDR[31:2];

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic [AW-1:0] word_idx;
    logic [1:0]    size;
    logic          out_of_range;
    logic          misaligned;
    logic          store_f3_ok;
    logic          load_f3_ok;
    logic          store_legal;
    logic          load_legal;

    assign word_idx = data_address_m[AW+1:2];
    assign size     = funct3_m[1:0];

    always_comb begin
        out_of_range = (data_address_m >= MEM_BYTES);
        misaligned   = ((size == 2'b01) && data_address_m[0]) ||
                       ((size == 2'b10) && (data_address_m[1:0] != 2'b00));
        // Stores only have signed-size encodings; loads reject 011/110/111.
        store_f3_ok  = !funct3_m[2] && (size != 2'b11);
        load_f3_ok   = (size != 2'b11) && (funct3_m != 3'b110);
        store_legal  = store_f3_ok && !out_of_range && !misaligned;
        load_legal   = load_f3_ok && !out_of_range && !misaligned;
    end

    // ------------------------------------------------------------------
    // Load data path: word read before any same-cycle store lands, so a
    // simultaneous load of the stored word sees the old contents.
    // ------------------------------------------------------------------
    logic [31:0] cur_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign cur_word = mem[word_idx];

    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = 16'h0000;
        ld_value = 32'h0000_0000;
        case (data_address_m[1:0])
            2'd0:    ld_byte = cur_word[7:0];
            2'd1:    ld_byte = cur_word[15:8];
            2'd2:    ld_byte = cur_word[23:16];
            default: ld_byte = cur_word[31:24];
        endcase
        ld_half = data_address_m[1] ? cur_word[31:16] : cur_word[15:0];
        case (funct3_m)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_value = cur_word;
            3'b100:  ld_value = {24'h00_0000, ld_byte};
            3'b101:  ld_value = {16'h0000, ld_half};
            default: ld_value = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Store data path: replicate the right-aligned data over all lanes and
    // let the byte enables pick which lanes replace the current word.
    // ------------------------------------------------------------------
    logic [3:0]  byte_en;
    logic [31:0] wr_lanes;
    logic [31:0] merged_word;

    always_comb begin
        byte_en     = 4'b0000;
        wr_lanes    = store_data_m;
        merged_word = cur_word;
        case (size)
            2'b00: begin
                byte_en  = 4'b0001 << data_address_m[1:0];
                wr_lanes = {4{store_data_m[7:0]}};
            end
            2'b01: begin
                byte_en  = data_address_m[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{store_data_m[15:0]}};
            end
            2'b10: begin
                byte_en  = 4'b1111;
                wr_lanes = store_data_m;
            end
            default: begin
                byte_en  = 4'b0000;
                wr_lanes = store_data_m;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                merged_word[8*b +: 8] = wr_lanes[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory, load register, error flag and store counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0000_0000;
            end
            read_data_w <= 32'h0000_0000;
            access_err  <= 1'b0;
            store_count <= 16'h0000;
        end else begin
            if (mem_read_m) begin
                if (load_legal) begin
                    read_data_w <= ld_value;
                end else begin
                    read_data_w <= 32'h0000_0000;
                    access_err  <= 1'b1;
                end
            end
            if (mem_write_m) begin
                if (store_legal) begin
                    mem[word_idx] <= merged_word;
                    if (store_count != 16'hFFFF) begin
                        store_count <= store_count + 16'd1;
                    end
                end else begin
                    access_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pass/fail state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if ((state == ST_RUN) && mem_write_m) begin
            if (!store_legal) begin
                state_next = ST_FAIL;
            end else if (data_address_m[31:2] == PASS_WORD) begin
                // Only a full word of the expected value ends the run well.
                if ((size == 2'b10) && (store_data_m == PASS_DATA)) begin
                    state_next = ST_PASS;
                end else begin
                    state_next = ST_FAIL;
                end
            end else if (data_address_m[31:2] != SCRATCH_WORD) begin
                state_next = ST_FAIL;
            end
        end
    end

    // Decoded straight from the state register, so both change on the edge
    // that performs the deciding store.
    assign done = (state != ST_RUN);
    assign pass = (state == ST_PASS);

endmodule
